crc_engine: RTL and testbench



---
 rtl/crc_pkg.sv | 47 ++++
 rtl/crc_step.sv | 26 ++
 rtl/crc_engine.sv | 156 +++++++++++++++
 tb/tb_crc_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC engine: standard algorithm presets, FSM state
// encoding and a bit-reversal helper.
package crc_pkg;

    typedef struct packed {
        int          w;
        logic [31:0] poly;
        logic [31:0] init;
        bit          refin;
        bit          refout;
        logic [31:0] xorout;
    } crc_cfg_t;

    localparam crc_cfg_t CRC16_MODBUS = '{
        w: 16, poly: 32'h0000_8005, init: 32'h0000_FFFF,
        refin: 1'b1, refout: 1'b1, xorout: 32'h0000_0000
    };

    localparam crc_cfg_t CRC16_CCITT_FALSE = '{
        w: 16, poly: 32'h0000_1021, init: 32'h0000_FFFF,
        refin: 1'b0, refout: 1'b0, xorout: 32'h0000_0000
    };

    localparam crc_cfg_t CRC32_ETH = '{
        w: 32, poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF,
        refin: 1'b1, refout: 1'b1, xorout: 32'hFFFF_FFFF
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] reverse_bits(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update over BPC message bits; bits_in[BPC-1] is applied
// first, so the whole slice is one chained shift/XOR network.
module crc_step #(
    parameter int          CRC_W = 16,
    parameter logic [31:0] POLY  = 32'h0000_8005,
    parameter int          BPC   = 1
) (
    input  logic [CRC_W-1:0] reg_in,
    input  logic [BPC-1:0]   bits_in,
    output logic [CRC_W-1:0] reg_out
);

    logic [CRC_W-1:0] acc;
    logic             fb;

    always_comb begin
        acc = reg_in;
        fb  = 1'b0;
        for (int i = BPC - 1; i >= 0; i--) begin
            fb  = acc[CRC_W-1] ^ bits_in[i];
            acc = {acc[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : '0);
        end
        reg_out = acc;
    end

endmodule

// File: rtl/crc_engine.sv
// Bit-sliced CRC generator: captures a message, feeds BPC bits per clock
// through crc_step and publishes the finalised CRC with a one-cycle valid.
module crc_engine
    import crc_pkg::*;
#(
    parameter int          CRC_W      = CRC16_MODBUS.w,
    parameter logic [31:0] POLY       = CRC16_MODBUS.poly,
    parameter logic [31:0] INIT       = CRC16_MODBUS.init,
    parameter bit          REFIN      = CRC16_MODBUS.refin,
    parameter bit          REFOUT     = CRC16_MODBUS.refout,
    parameter logic [31:0] XOROUT     = CRC16_MODBUS.xorout,
    parameter int          DATA_BYTES = 12,
    parameter int          BPC        = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [$clog2(DATA_BYTES+1)-1:0]   len_in,
    input  logic [8*DATA_BYTES-1:0]           data_in,
    output logic                              busy,
    output logic                              valid,
    output logic [CRC_W-1:0]                  crc_out
);

    localparam int BUF_W = 8 * DATA_BYTES;
    localparam int LEN_W = $clog2(DATA_BYTES + 1);
    localparam int CNT_W = $clog2(BUF_W / BPC + 1);

    generate
        if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bad_bpc
            $error("crc_engine: BPC must be 1, 2, 4 or 8");
        end
        if (CRC_W < 8 || CRC_W > 32) begin : g_bad_width
            $error("crc_engine: CRC_W must lie in 8..32");
        end
        if ((POLY >> CRC_W) != 0 || (INIT >> CRC_W) != 0 || (XOROUT >> CRC_W) != 0) begin : g_bad_const
            $error("crc_engine: POLY/INIT/XOROUT wider than CRC_W");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [BUF_W-1:0]  buf_reg, buf_next, cap;
    logic [CRC_W-1:0]  crc_reg, crc_next, step_out;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, n_load;
    logic              busy_reg, busy_next;
    logic              valid_reg, valid_next;
    logic [CRC_W-1:0]  crc_out_reg, crc_out_next;
    logic [LEN_W-1:0]  l_eff;

    // Byte reflection is applied once at capture so the shifter always drains MSB-first.
    generate
        for (genvar gi = 0; gi < BUF_W; gi++) begin : g_cap
            if (REFIN) begin : g_ref
                assign cap[gi] = data_in[(gi / 8) * 8 + 7 - (gi % 8)];
            end else begin : g_dir
                assign cap[gi] = data_in[gi];
            end
        end
    endgenerate

    assign l_eff  = (len_in > LEN_W'(DATA_BYTES)) ? LEN_W'(DATA_BYTES) : len_in;
    assign n_load = CNT_W'(l_eff) * CNT_W'(8 / BPC);

    crc_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .BPC   (BPC)
    ) u_step (
        .reg_in  (crc_reg),
        .bits_in (buf_reg[BUF_W-1 -: BPC]),
        .reg_out (step_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = (l_eff == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (abort)                        state_next = ST_IDLE;
                else if (cnt_reg == CNT_W'(1))    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        buf_next     = buf_reg;
        crc_next     = crc_reg;
        cnt_next     = cnt_reg;
        busy_next    = busy_reg;
        valid_next   = 1'b0;
        crc_out_next = crc_out_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    buf_next  = cap;
                    crc_next  = INIT[CRC_W-1:0];
                    cnt_next  = n_load;
                    busy_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    busy_next = 1'b0;
                    cnt_next  = '0;
                end else begin
                    crc_next = step_out;
                    buf_next = buf_reg << BPC;
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy_next = 1'b0;
                if (!abort) begin
                    valid_next   = 1'b1;
                    crc_out_next = CRC_W'((REFOUT ? reverse_bits(32'(crc_reg), CRC_W)
                                                  : 32'(crc_reg)) ^ XOROUT);
                end
            end
            default: busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_reg     <= '0;
            crc_reg     <= INIT[CRC_W-1:0];
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            crc_out_reg <= '0;
        end else begin
            buf_reg     <= buf_next;
            crc_reg     <= crc_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            valid_reg   <= valid_next;
            crc_out_reg <= crc_out_next;
        end
    end

    assign busy    = busy_reg;
    assign valid   = valid_reg;
    assign crc_out = crc_out_reg;

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench for crc_engine: MODBUS, CCITT-FALSE at four slice widths and
// CRC-32/Ethernet instances, with a negedge monitor checking CRC and latency.
module tb_crc_engine;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MODBUS instance (defaults)
    logic        m_start, m_abort, m_busy, m_valid;
    logic [3:0]  m_len;
    logic [95:0] m_data;
    logic [15:0] m_crc;

    // CCITT-FALSE instances, BPC = 1, 2, 4, 8
    logic        c_start;
    logic [3:0]  c_len;
    logic [95:0] c_data;
    logic        c_busy  [4];
    logic        c_valid [4];
    logic [15:0] c_crc   [4];

    // CRC-32 Ethernet instance
    logic         e_start, e_busy, e_valid;
    logic [4:0]   e_len;
    logic [127:0] e_data;
    logic [31:0]  e_crc;

    crc_engine u_modbus (
        .clk(clk), .rst(rst), .start(m_start), .abort(m_abort),
        .len_in(m_len), .data_in(m_data),
        .busy(m_busy), .valid(m_valid), .crc_out(m_crc)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ccitt
            crc_engine #(
                .CRC_W(CRC16_CCITT_FALSE.w), .POLY(CRC16_CCITT_FALSE.poly),
                .INIT(CRC16_CCITT_FALSE.init), .REFIN(CRC16_CCITT_FALSE.refin),
                .REFOUT(CRC16_CCITT_FALSE.refout), .XOROUT(CRC16_CCITT_FALSE.xorout),
                .DATA_BYTES(12), .BPC(1 << gi)
            ) u_ccitt (
                .clk(clk), .rst(rst), .start(c_start), .abort(1'b0),
                .len_in(c_len), .data_in(c_data),
                .busy(c_busy[gi]), .valid(c_valid[gi]), .crc_out(c_crc[gi])
            );
        end
    endgenerate

    crc_engine #(
        .CRC_W(CRC32_ETH.w), .POLY(CRC32_ETH.poly), .INIT(CRC32_ETH.init),
        .REFIN(CRC32_ETH.refin), .REFOUT(CRC32_ETH.refout), .XOROUT(CRC32_ETH.xorout),
        .DATA_BYTES(16), .BPC(1)
    ) u_eth (
        .clk(clk), .rst(rst), .start(e_start), .abort(1'b0),
        .len_in(e_len), .data_in(e_data),
        .busy(e_busy), .valid(e_valid), .crc_out(e_crc)
    );

    // Scoreboard: index 0 modbus, 1..4 ccitt BPC 1/2/4/8, 5 eth; entry = {due_cycle, crc}
    logic [5:0]  vld;
    logic [31:0] crc_a [6];
    logic [63:0] exp_q [6][$];
    string       names [6] = '{"modbus", "ccitt_b1", "ccitt_b2", "ccitt_b4", "ccitt_b8", "eth"};

    assign vld      = {e_valid, c_valid[3], c_valid[2], c_valid[1], c_valid[0], m_valid};
    assign crc_a[0] = {16'h0, m_crc};
    assign crc_a[1] = {16'h0, c_crc[0]};
    assign crc_a[2] = {16'h0, c_crc[1]};
    assign crc_a[3] = {16'h0, c_crc[2]};
    assign crc_a[4] = {16'h0, c_crc[3]};
    assign crc_a[5] = e_crc;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [63:0] mon_e;
    always @(negedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (rst && vld[k]) begin
                if (exp_q[k].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_unexpected_valid: got valid with crc %h, expected no valid", names[k], crc_a[k]);
                end else begin
                    mon_e = exp_q[k].pop_front();
                    check({names[k], "_crc"}, crc_a[k], mon_e[31:0]);
                    check({names[k], "_cycle"}, cyc, mon_e[63:32]);
                    $display("[TB] %s txn crc=%h cycle=%0d", names[k], crc_a[k], cyc);
                end
            end
        end
    end

    int bcnt = 0;
    int last_busy = 0;
    always @(negedge clk) begin
        if (m_busy) begin
            bcnt++;
        end else begin
            if (bcnt != 0) last_busy = bcnt;
            bcnt = 0;
        end
    end

    // Reference CRC-16/MODBUS in the reflected (right-shifting) form.
    function automatic logic [15:0] modbus_model(input logic [95:0] d, input int len);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {8'h00, d[95-8*i -: 8]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic int pending();
        int p = 0;
        for (int k = 0; k < 6; k++) p += exp_q[k].size();
        return p;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pending() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d outstanding results after %0d cycles, expected 0", pending(), budget);
            for (int k = 0; k < 6; k++) exp_q[k].delete();
        end
    endtask

    task automatic m_go(input logic [95:0] d, input logic [3:0] l, input bit push,
                        input logic [15:0] exp, input int n);
        m_data  = d;
        m_len   = l;
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        if (push) exp_q[0].push_back({cyc + n + 1, 16'h0, exp});
    endtask

    logic [95:0] d9, hw;
    logic [15:0] hw_crc;
    int          wn;

    initial begin
        d9      = {"123456789", 24'h0};
        hw      = "Hello, World";
        hw_crc  = modbus_model(hw, 12);
        m_start = 0; m_abort = 0; m_len = 0; m_data = '0;
        c_start = 0; c_len = 0; c_data = '0;
        e_start = 0; e_len = 0; e_data = '0;

        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, m_busy}, 32'h0);
        check("reset_valid", {31'h0, m_valid}, 32'h0);
        check("reset_crc_modbus", {16'h0, m_crc}, 32'h0);
        check("reset_crc_eth", e_crc, 32'h0);
        check("reset_busy_all", {27'h0, c_busy[0], c_busy[1], c_busy[2], c_busy[3], e_busy}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // MODBUS check value, busy window of N+1 cycles
        m_go(d9, 4'd9, 1, 16'h4B37, 72);
        drain(200);
        @(negedge clk);
        check("modbus_busy_len", last_busy, 32'd73);

        // CCITT-FALSE at all slice widths
        c_data  = d9;
        c_len   = 4'd9;
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        for (int k = 0; k < 4; k++) exp_q[k+1].push_back({cyc + 72 / (1 << k) + 1, 16'h0, 16'h29B1});
        drain(200);

        // CRC-32 Ethernet
        e_data  = {"123456789", 56'h0};
        e_len   = 5'd9;
        e_start = 1'b1;
        @(negedge clk);
        e_start = 1'b0;
        exp_q[5].push_back({cyc + 73, 32'hCBF43926});
        drain(200);

        // Zero length, then clamped length against the full-buffer run
        m_go(d9, 4'd0, 1, 16'hFFFF, 0);
        drain(20);
        m_go(hw, 4'd12, 1, hw_crc, 96);
        drain(200);
        m_go(hw, 4'd15, 1, hw_crc, 96);
        drain(200);

        // Abort on RUN cycle 20: no valid, busy low, crc_out held
        m_go(d9, 4'd9, 0, 16'h0, 0);
        repeat (19) @(negedge clk);
        m_abort = 1'b1;
        @(negedge clk);
        m_abort = 1'b0;
        check("abort_busy", {31'h0, m_busy}, 32'h0);
        check("abort_crc_hold", {16'h0, m_crc}, {16'h0, hw_crc});
        repeat (100) @(negedge clk);
        check("abort_crc_hold_late", {16'h0, m_crc}, {16'h0, hw_crc});

        // Start pulse during RUN ignored, then back-to-back start after valid
        m_go(d9, 4'd9, 1, 16'h4B37, 72);
        repeat (5) @(negedge clk);
        m_data  = hw;
        m_len   = 4'd0;
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        wn = 0;
        while (!m_valid && wn < 200) begin
            @(negedge clk);
            wn++;
        end
        m_go(hw, 4'd12, 1, hw_crc, 96);
        drain(300);

        // Asynchronous reset mid-RUN, then a clean transaction
        m_go(d9, 4'd9, 0, 16'h0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun_rst_busy", {31'h0, m_busy}, 32'h0);
        check("midrun_rst_valid", {31'h0, m_valid}, 32'h0);
        check("midrun_rst_crc", {16'h0, m_crc}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_go(d9, 4'd9, 1, 16'h4B37, 72);
        drain(200);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
